// File: rtl/instr_field_encoder.sv
// Field-bundle to IR-word encoder with handshaked, auto-addressed instruction-memory writes.
// Optional immediate range checking for I/B formats is enabled by defining IMM_RANGE_CHECK_EN.
module instr_field_encoder #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                base_load,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          opcode,
    input  logic [1:0]          fmt,
    input  logic [15:0]         ra_sel,
    input  logic [15:0]         rb_sel,
    input  logic [15:0]         rc_sel,
    input  logic signed [31:0]  imm,
    input  logic [3:0]          cond,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_data,
    output logic                mem_we,
    input  logic                mem_ack,
    output logic [31:0]         ir_out,
    output logic [CNT_W-1:0]    words_written,
    output logic                err_onehot,
    output logic                err_range,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_B = 2'd2;

    // Returns {error, index}; error when zero or several bits are set.
    function automatic logic [4:0] onehot_enc(input logic [15:0] sel);
        logic [3:0] idx;
        logic [4:0] ones;
        idx  = 4'd0;
        ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (sel[i]) begin
                idx  = i[3:0];
                ones = ones + 5'd1;
            end
        end
        if (ones != 5'd1)
            return 5'b1_0000;
        return {1'b0, idx};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + CNT_W'(1);
    endfunction

    function automatic logic [31:0] pack_word(
        input logic [4:0]  op,
        input logic [1:0]  f,
        input logic [3:0]  a,
        input logic [3:0]  b,
        input logic [3:0]  c,
        input logic [18:0] im,
        input logic [3:0]  cc
    );
        case (f)
            2'd0:    return {op, a, b, c, 15'd0};
            2'd1:    return {op, a, b, im};
            2'd2:    return {op, a, cc, im};
            default: return {op, a, 23'd0};
        endcase
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    function automatic logic imm_in_range(input logic signed [31:0] v);
        return (v >= -32'sd262144) && (v <= 32'sd262143);
    endfunction
`endif

    state_t             state, state_nxt;
    logic               rdy;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               write_done;

    logic [4:0]         opcode_p0;
    logic [1:0]         fmt_p0;
    logic [15:0]        ra_p0, rb_p0, rc_p0;
    logic [18:0]        imm_p0;
    logic [3:0]         cond_p0;

    logic [4:0]         enc_a, enc_b, enc_c;
    logic               uses_rb, uses_rc;
    logic               onehot_bad;
    logic [31:0]        word;

    assign accept     = (state == S_IDLE) && rdy && in_valid;
    assign write_done = (state == S_WRITE) && mem_ack;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ENCODE;
            S_ENCODE: state_nxt = S_WRITE;
            S_WRITE:  if (mem_ack) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
            rdy   <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy   <= (state_nxt == S_IDLE);
        end
    end

    // Base load wins in IDLE so a simultaneous acceptance writes at the new base.
    always_ff @(posedge clock) begin
        if (!clear) begin
            addr  <= '0;
            count <= '0;
        end else if ((state == S_IDLE) && base_load) begin
            addr <= base_addr;
        end else if (write_done) begin
            addr  <= addr + ADDR_W'(1);
            count <= sat_inc(count);
        end
    end

    // Stage p0: field capture on acceptance (data only, no reset)
    always_ff @(posedge clock) begin
        if (accept) begin
            opcode_p0 <= opcode;
            fmt_p0    <= fmt;
            ra_p0     <= ra_sel;
            rb_p0     <= rb_sel;
            rc_p0     <= rc_sel;
            imm_p0    <= imm[18:0];
            cond_p0   <= cond;
        end
    end

    always_comb begin
        enc_a      = onehot_enc(ra_p0);
        enc_b      = onehot_enc(rb_p0);
        enc_c      = onehot_enc(rc_p0);
        uses_rb    = (fmt_p0 == FMT_R) || (fmt_p0 == FMT_I);
        uses_rc    = (fmt_p0 == FMT_R);
        onehot_bad = enc_a[4] | (uses_rb & enc_b[4]) | (uses_rc & enc_c[4]);
        word       = pack_word(opcode_p0, fmt_p0, enc_a[3:0], enc_b[3:0],
                               enc_c[3:0], imm_p0, cond_p0);
    end

    // Stage p1: packed word registered at the end of ENCODE, held through WRITE
    always_ff @(posedge clock) begin
        if (!clear) begin
            mem_data   <= '0;
            ir_out     <= '0;
            err_onehot <= 1'b0;
        end else if (state == S_ENCODE) begin
            mem_data   <= word;
            ir_out     <= word;
            err_onehot <= err_onehot | onehot_bad;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic imm_oor_p0;
    logic err_range_q;

    always_ff @(posedge clock) begin
        if (accept)
            imm_oor_p0 <= !imm_in_range(imm);
    end

    always_ff @(posedge clock) begin
        if (!clear)
            err_range_q <= 1'b0;
        else if ((state == S_ENCODE) && ((fmt_p0 == FMT_I) || (fmt_p0 == FMT_B)) && imm_oor_p0)
            err_range_q <= 1'b1;
    end

    assign err_range = err_range_q;
`else
    // Upper immediate bits are simply truncated in this build.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:19];
    assign err_range     = 1'b0;
`endif

    assign in_ready      = rdy;
    assign mem_we        = (state == S_WRITE);
    assign busy          = (state != S_IDLE);
    assign mem_addr      = addr;
    assign words_written = count;

endmodule

// File: tb/tb_instr_field_encoder.sv
// Self-checking bench for instr_field_encoder: directed vector table, handshake/wrap/reset
// sequences and randomized bundles checked against a behavioural model.
module tb_instr_field_encoder;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 16;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               clear = 1'b0;
    logic               base_load = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4:0]         opcode = '0;
    logic [1:0]         fmt = '0;
    logic [15:0]        ra_sel = '0, rb_sel = '0, rc_sel = '0;
    logic signed [31:0] imm = '0;
    logic [3:0]         cond = '0;
    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_data;
    logic               mem_we;
    logic               mem_ack = 1'b0;
    logic [31:0]        ir_out;
    logic [CNT_W-1:0]   words_written;
    logic               err_onehot, err_range, busy;

    instr_field_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .clear(clear), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .fmt(fmt),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rc_sel(rc_sel), .imm(imm), .cond(cond),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
        .ir_out(ir_out), .words_written(words_written), .err_onehot(err_onehot),
        .err_range(err_range), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] m_addr;
    int                m_cnt;
    bit                m_err1, m_err2;

    typedef struct {
        logic [4:0]         op;
        logic [1:0]         f;
        logic [15:0]        ra, rb, rc;
        logic signed [31:0] im;
        logic [3:0]         cc;
        logic [31:0]        word;
        bit                 e1;
        bit                 e2;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit m_bad(input logic [15:0] s);
        return $countones(s) != 1;
    endfunction

    function automatic int m_idx(input logic [15:0] s);
        for (int i = 0; i < 16; i++)
            if (s == (16'h0001 << i)) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_word(input logic [4:0] op, input logic [1:0] f,
                                           input logic [15:0] ra, input logic [15:0] rb,
                                           input logic [15:0] rc, input logic signed [31:0] im,
                                           input logic [3:0] cc);
        longint w, i19;
        i19 = longint'(im) % 524288;
        if (i19 < 0) i19 = i19 + 524288;
        w = longint'(op) * 134217728 + longint'(m_idx(ra)) * 8388608;
        case (f)
            2'd0: w = w + longint'(m_idx(rb)) * 524288 + longint'(m_idx(rc)) * 32768;
            2'd1: w = w + longint'(m_idx(rb)) * 524288 + i19;
            2'd2: w = w + longint'(cc) * 524288 + i19;
            default: ;
        endcase
        return w[31:0];
    endfunction

    task automatic m_errs(input logic [1:0] f, input logic [15:0] ra, input logic [15:0] rb,
                          input logic [15:0] rc, input logic signed [31:0] im);
        if (m_bad(ra) || ((f == 2'd0 || f == 2'd1) && m_bad(rb)) || (f == 2'd0 && m_bad(rc)))
            m_err1 = 1'b1;
        if (RANGE_EN && (f == 2'd1 || f == 2'd2) && (im < -262144 || im > 262143))
            m_err2 = 1'b1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        in_valid = 1'b0;
        mem_ack = 1'b0;
        base_load = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_we", mem_we, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_cnt", words_written, 0);
        chk("rst_err1", err_onehot, 0);
        chk("rst_err2", err_range, 0);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready_after", in_ready, 1);
        m_addr = '0;
        m_cnt  = 0;
        m_err1 = 1'b0;
        m_err2 = 1'b0;
    endtask

    // Sends one bundle, checks the write phase, then acks (unless abort) and checks IDLE state.
    task automatic send(input logic [4:0] op, input logic [1:0] f, input logic [15:0] ra,
                        input logic [15:0] rb, input logic [15:0] rc, input logic signed [31:0] im,
                        input logic [3:0] cc, input logic [31:0] ew, input bit bl,
                        input logic [ADDR_W-1:0] ba, input int dly, input bit abort,
                        input string tag);
        int n;
        logic [ADDR_W-1:0] wa;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got in_ready 0 expected 1", tag);
        end
        opcode = op; fmt = f; ra_sel = ra; rb_sel = rb; rc_sel = rc; imm = im; cond = cc;
        base_load = bl; base_addr = ba; in_valid = 1'b1;
        if (bl) m_addr = ba;
        wa = m_addr;
        @(posedge clock);
        #1;
        in_valid = 1'b0; base_load = 1'b0;
        opcode = 5'($urandom); ra_sel = 16'($urandom); rb_sel = 16'($urandom);
        rc_sel = 16'($urandom); imm = $urandom; cond = 4'($urandom);
        @(negedge clock);
        chk({tag, "_encode_we"}, mem_we, 0);
        chk({tag, "_encode_ready"}, in_ready, 0);
        @(negedge clock);
        chk({tag, "_we"}, mem_we, 1);
        chk({tag, "_addr"}, mem_addr, wa);
        chk({tag, "_data"}, mem_data, ew);
        for (int d = 0; d < dly; d++) begin
            in_valid = 1'b1;
            base_load = 1'b1;
            base_addr = ADDR_W'($urandom);
            fmt = 2'($urandom);
            @(negedge clock);
            chk({tag, "_stall_we"}, mem_we, 1);
            chk({tag, "_stall_addr"}, mem_addr, wa);
            chk({tag, "_stall_data"}, mem_data, ew);
            chk({tag, "_stall_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        base_load = 1'b0;
        if (!abort) begin
            mem_ack = 1'b1;
            @(posedge clock);
            #1;
            mem_ack = 1'b0;
            m_addr = m_addr + 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            @(negedge clock);
            chk({tag, "_done_ready"}, in_ready, 1);
            chk({tag, "_done_we"}, mem_we, 0);
            chk({tag, "_done_busy"}, busy, 0);
            chk({tag, "_ir"}, ir_out, ew);
            chk({tag, "_count"}, words_written, m_cnt);
            chk({tag, "_next_addr"}, mem_addr, m_addr);
            chk({tag, "_err_onehot"}, err_onehot, m_err1);
            chk({tag, "_err_range"}, err_range, m_err2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]         r_op;
        logic [1:0]         r_f;
        logic [15:0]        r_s[3];
        logic signed [31:0] r_im;
        logic [3:0]         r_cc;
        bit                 r_bl;
        logic [ADDR_W-1:0]  r_ba;

        tbl[0] = '{5'b00011, 2'd0, 16'h0020, 16'h0004, 16'h0008, 32'sd0, 4'h0, 32'h1A918000, 0, 0};
        tbl[1] = '{5'b01100, 2'd1, 16'h0002, 16'h0004, 16'hFFFF, -32'sd5, 4'h0, 32'h6097FFFB, 0, 0};
        tbl[2] = '{5'b10101, 2'd2, 16'h8000, 16'h0000, 16'h0000, 32'sh12345, 4'hA, 32'hAFD12345, 0, 0};
        tbl[3] = '{5'b11111, 2'd3, 16'h0400, 16'h0000, 16'h0000, 32'sh7FFFFFFF, 4'hF, 32'hFD000000, 0, 0};
        tbl[4] = '{5'b00001, 2'd1, 16'h0001, 16'h0001, 16'h0000, 32'sh00040000, 4'h0, 32'h08040000, 0, 1};
        tbl[5] = '{5'b00011, 2'd0, 16'h0003, 16'h0004, 16'h0008, 32'sd0, 4'h0, 32'h18118000, 1, 1};
        tbl[6] = '{5'b00011, 2'd0, 16'h0020, 16'h0004, 16'h0008, 32'sd0, 4'h0, 32'h1A918000, 1, 1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            m_err1 = tbl[i].e1;
            m_err2 = tbl[i].e2 & RANGE_EN;
            send(tbl[i].op, tbl[i].f, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].im, tbl[i].cc,
                 tbl[i].word, (i == 0), 9'h010, (i == 1) ? 5 : i % 3, 1'b0, $sformatf("vec%0d", i));
        end

        // Address wrap followed by a reset in the middle of the second write.
        do_reset();
        send(5'b00011, 2'd0, 16'h0020, 16'h0004, 16'h0008, 32'sd0, 4'h0, 32'h1A918000,
             1'b1, 9'h1FF, 0, 1'b0, "wrap0");
        chk("wrap_addr_zero", mem_addr, 9'h000);
        send(5'b01100, 2'd1, 16'h0002, 16'h0004, 16'h0000, -32'sd5, 4'h0, 32'h6097FFFB,
             1'b0, 9'h000, 2, 1'b1, "wrap1");
        clear = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_we", mem_we, 0);
        chk("abort_cnt", words_written, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_busy", busy, 0);
        do_reset();

        // Randomized bundles against the behavioural model.
        for (int k = 0; k < 150; k++) begin
            r_op = 5'($urandom);
            r_f  = 2'($urandom);
            for (int j = 0; j < 3; j++)
                r_s[j] = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                     : (16'h0001 << $urandom_range(0, 15));
            r_im = ($urandom_range(0, 3) == 0) ? $signed($urandom)
                                               : $signed(32'($urandom_range(0, 524287)) - 32'd262144);
            r_cc = 4'($urandom);
            r_bl = ($urandom_range(0, 9) == 0);
            r_ba = ADDR_W'($urandom);
            m_errs(r_f, r_s[0], r_s[1], r_s[2], r_im);
            send(r_op, r_f, r_s[0], r_s[1], r_s[2], r_im, r_cc,
                 m_word(r_op, r_f, r_s[0], r_s[1], r_s[2], r_im, r_cc),
                 r_bl, r_ba, $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_field_encoder.md
Name: instr_field_encoder

Overview:
- Reverse path of the datapath's select-and-encode logic.
- Accepts instruction fields: opcode, format, one-hot register selects (Ra/Rb/Rc), immediate and condition.
- Encodes each one-hot select to a 4-bit index and packs a 32-bit instruction word in the same IR layout the decode side consumes.
- Writes each word into instruction memory at an auto-incrementing address over a write/ack handshake. Used by the program-load and self-test path.

Parameters:
- ADDR_W, 9, memory word-address width; address counter wraps modulo 2^ADDR_W.
- CNT_W, 16, width of words_written counter (saturating).

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-low reset
- base_load  in  1  load base_addr into address counter (honoured in IDLE only)
- base_addr  in  ADDR_W  start address
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- opcode  in  5  instruction opcode -> IR[31:27]
- fmt  in  2  0=R, 1=I, 2=B, 3=J
- ra_sel  in  16  one-hot Ra select
- rb_sel  in  16  one-hot Rb select
- rc_sel  in  16  one-hot Rc select
- imm  in  32  signed immediate
- cond  in  4  branch condition code (B format)
- mem_addr  out  ADDR_W  write address
- mem_data  out  32  packed instruction word
- mem_we  out  1  write request
- mem_ack  in  1  memory accepted write
- ir_out  out  32  last packed word (held)
- words_written  out  CNT_W  completed writes, saturates at all-ones
- err_onehot  out  1  sticky: a used select was not exactly one-hot
- err_range  out  1  sticky: immediate out of range (feature only)
- busy  out  1  state != IDLE

Behaviour:
- Single clock domain. Reset is synchronous, active-low on clear.
- Reset values: all outputs 0, state IDLE, address counter 0. in_ready = 1 from the first cycle after clear is released.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, capture all inputs and go to ENCODE.
  - ENCODE: one cycle. Build the word, register it into mem_data and ir_out, go to WRITE.
  - WRITE: mem_we=1; mem_addr and mem_data held stable. On mem_ack=1 (sampled at clock edge, may arrive in the first WRITE cycle): address +1, words_written +1 (saturating), go to IDLE.
- Latency: bundle accepted at edge t; mem_we high from t+2; minimum 3 cycles per word. in_ready is 0 outside IDLE.
- One-hot encode: index = position of the single set bit (16'h0001 -> 0, 16'h8000 -> 15).
  - Zero or multiple bits set: field = 4'b0000 and err_onehot set.
  - Selects a format does not use are ignored (no error, no field bits).
- Packing:
  - R: [31:27]=opcode, [26:23]=Ra, [22:19]=Rb, [18:15]=Rc, [14:0]=0.
  - I: opcode, Ra, Rb, [18:0]=imm[18:0].
  - B: opcode, Ra, [22:19]=cond, [18:0]=imm[18:0].
  - J: opcode, Ra, [22:0]=0.
- base_load:
  - In IDLE, loads the counter; if simultaneous with acceptance, the new base is used for that word.
  - Outside IDLE it is ignored.
- Address wraps from 2^ADDR_W-1 to 0 with no flag.
- Sticky errors clear only on reset.
- clear low in any state, including mid-WRITE: immediate return to reset values. mem_we drops the next edge and the pending word is discarded (not counted).

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: for I/B formats, err_range is set when imm is outside the signed 19-bit range [-262144, 262143]. The word is still written with imm[18:0].
- Undefined: no check; err_range tied to 0; imm silently truncated.

Test Plan:
- Reset, base_load 0x010, R: opcode 5'b00011, ra 16'h0020, rb 16'h0004, rc 16'h0008 -> mem_we at t+2, mem_addr 0x010, mem_data 0x1A918000, ack -> words_written 1, in_ready 1.
- I: opcode 5'b01100, ra 16'h0002, rb 16'h0004, imm -5 -> mem_data 0x6097FFFB; with macro, err_range 0.
- imm 0x00040000, I format, macro defined -> err_range 1, C field 0x40000; macro undefined -> err_range 0, same word.
- R with ra 16'h0003 -> Ra field 0000, err_onehot 1, stays 1 after later valid bundles; J with rb 16'h0000 -> no error.
- mem_ack low 5 cycles -> mem_we, mem_addr, mem_data stable, in_ready 0, in_valid ignored; ack -> IDLE next cycle.
- ADDR_W=9, base 0x1FF, two bundles -> addresses 0x1FF then 0x000. clear low during second WRITE -> mem_we 0, words_written 0, address 0.
